// File: rtl/seq_arith_pkg.sv
// Shared types for the word-serial arithmetic blocks (sequential adder/subtractor).
//   DefaultWidth : default operand word width in bits
//   state_e      : packet-tracking FSM state
//   sideband_t   : per-word packet framing flags {first, last}
package seq_arith_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic {
    StIdle,
    StBusy
  } state_e;

  typedef struct packed {
    logic first;
    logic last;
  } sideband_t;

endpackage

// File: rtl/seq_pipe_reg.sv
// Single valid/ready pipeline register stage.
// The stage loads whenever it is empty or its current word leaves in the same cycle.
// Ports:
//   clk, rst             : clock, synchronous active-high reset (clears valid and data)
//   in_valid/in_ready    : upstream handshake, in_data is the word offered
//   out_valid/out_ready  : downstream handshake, out_data is the held word
module seq_pipe_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      // Data only moves with a real word, so X on an idle bus never reaches the register.
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/seq_subtractor.sv
// Pipelined word-serial multi-precision subtractor, least-significant word first.
// Stage S1 holds operands and flags; the subtraction happens as a word moves S1 -> S2,
// with the borrow chained across words of a packet; S2 holds the result.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready             : input handshake
//   in_first/in_last, in_a, in_b  : packet framing, minuend word, subtrahend word
//   out_valid/out_ready           : output handshake
//   out_diff, out_borrow          : difference word, borrow out of this word
//   out_first/out_last            : framing flags echoed from the input word
//   out_zero                      : only with SEQ_SUBTRACTOR_ZERO_FLAG_EN defined; on the last
//                                   word, 1 when every difference word of the packet was zero
module seq_subtractor
  import seq_arith_pkg::*;
#(
  parameter int unsigned W = DefaultWidth
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic         in_last,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_diff,
  output logic         out_borrow,
  output logic         out_first,
  output logic         out_last
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
  ,
  output logic         out_zero
`endif
);

  localparam int unsigned S1W = 2 * W + 2;
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
  localparam int unsigned S2W = W + 4;
`else
  localparam int unsigned S2W = W + 3;
`endif

  sideband_t      in_sb, s1_sb;
  logic [S1W-1:0] s1_in, s1_data;
  logic [S2W-1:0] s2_in, s2_data;
  logic           s1_valid, s2_in_ready;
  logic           s1_fire;
  logic [W-1:0]   s1_a, s1_b;
  logic           pkt_start, b_in;
  logic [W:0]     sub;
  state_e         state_q, state_d;
  logic           borrow_q, borrow_d;

  assign in_sb = '{first: in_first, last: in_last};
  assign s1_in = {in_a, in_b, in_sb};

  seq_pipe_reg #(
    .Width(S1W)
  ) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (s1_in),
    .out_valid(s1_valid),
    .out_ready(s2_in_ready),
    .out_data (s1_data)
  );

  assign s1_fire = s1_valid && s2_in_ready;

  always_comb begin
    s1_sb     = sideband_t'(s1_data[1:0]);
    s1_b      = s1_data[W+1:2];
    s1_a      = s1_data[2*W+1:W+2];
    // A word arriving while idle starts a packet even without its first flag.
    pkt_start = s1_sb.first || (state_q == StIdle);
    b_in      = pkt_start ? 1'b0 : borrow_q;
    sub       = {1'b0, s1_a} - {1'b0, s1_b} - {{W{1'b0}}, b_in};
    state_d   = state_q;
    borrow_d  = borrow_q;
    if (s1_fire) begin
      state_d  = s1_sb.last ? StIdle : StBusy;
      borrow_d = sub[W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      borrow_q <= borrow_d;
    end
  end

`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
  logic zero_acc_q, zero_acc_d, zero_cur;

  always_comb begin
    zero_cur   = (pkt_start ? 1'b1 : zero_acc_q) && (sub[W-1:0] == '0);
    zero_acc_d = zero_acc_q;
    if (s1_fire) begin
      zero_acc_d = zero_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_acc_q <= 1'b0;
    end else begin
      zero_acc_q <= zero_acc_d;
    end
  end

  assign s2_in    = {zero_cur && s1_sb.last, sub, s1_sb};
  assign out_zero = s2_data[W+3];
`else
  assign s2_in = {sub, s1_sb};
`endif

  seq_pipe_reg #(
    .Width(S2W)
  ) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s1_valid),
    .in_ready (s2_in_ready),
    .in_data  (s2_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (s2_data)
  );

  assign out_first  = s2_data[1];
  assign out_last   = s2_data[0];
  assign out_diff   = s2_data[W+1:2];
  assign out_borrow = s2_data[W+2];

endmodule

// File: tb/tb_seq_subtractor.sv
// Self-checking bench for seq_subtractor: directed steps, scoreboard of expected words.
module tb_seq_subtractor;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_first, in_last;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_borrow, out_first, out_last;
  logic [W-1:0] out_diff;
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
  logic         out_zero;
`endif

  seq_subtractor #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_borrow(out_borrow),
    .out_first (out_first),
    .out_last  (out_last)
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         first;
    logic         last;
    logic         zero;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  // Reference model state for the borrow chain
  logic m_borrow = 1'b0;
  logic m_busy = 1'b0;
  logic m_zero = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic f, input logic l);
    logic       start, bin, zr;
    logic [W:0] r;
    exp_t       x;
    start = f || !m_busy;
    bin   = start ? 1'b0 : m_borrow;
    r     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    zr    = (start ? 1'b1 : m_zero) && (r[W-1:0] == '0);
    x.diff   = r[W-1:0];
    x.borrow = r[W];
    x.first  = f;
    x.last   = l;
    x.zero   = zr && l;
    sb_q.push_back(x);
    m_borrow = r[W];
    m_busy   = !l;
    m_zero   = zr;
  endtask

  // Call aligned to posedge+1; returns aligned to posedge+1 after acceptance.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic f, input logic l);
    logic rdy;
    bit   done;
    done     = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_first = f;
    in_last  = l;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        done = 1;
        model_push(a, b, f, l);
      end
    end
    #1;
    in_valid = 1'b0;
    in_a     = 'x;
    in_b     = 'x;
    in_first = 1'b0;
    in_last  = 1'b0;
    if (!done) check("accept_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_empty", sb_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: compare each output transfer with the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("diff", {24'd0, out_diff}, {24'd0, e.diff});
        check("borrow", {31'd0, out_borrow}, {31'd0, e.borrow});
        check("first", {31'd0, out_first}, {31'd0, e.first});
        check("last", {31'd0, out_last}, {31'd0, e.last});
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
        check("zero", {31'd0, out_zero}, {31'd0, e.zero});
`endif
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_diff", {24'd0, out_diff}, 32'd0);
    check("rst_out_borrow", {31'd0, out_borrow}, 32'd0);
    check("rst_out_first", {31'd0, out_first}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    @(posedge clk);
    #1;

    // Single word and latency: valid rises after the second edge counting acceptance
    send_word(8'h50, 8'h20, 1'b1, 1'b1);
    @(negedge clk);
    check("lat_edge1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_edge2", {31'd0, out_valid}, 32'd1);
    drain();

    // Underflow wrap
    send_word(8'h00, 8'h01, 1'b1, 1'b1);
    drain();

    // 16-bit packet 0x0100 - 0x0001
    send_word(8'h00, 8'h01, 1'b1, 1'b0);
    send_word(8'h01, 8'h00, 1'b0, 1'b1);
    drain();

    // Borrow-in with 0x00 - 0xFF
    send_word(8'h00, 8'h01, 1'b1, 1'b0);
    send_word(8'h00, 8'hFF, 1'b0, 1'b1);
    drain();

    // Random 3-word packet back to back
    send_word(8'($urandom), 8'($urandom), 1'b1, 1'b0);
    send_word(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    send_word(8'($urandom), 8'($urandom), 1'b0, 1'b1);
    drain();

    // Backpressure: out_ready low for 5 cycles
    out_ready = 1'b0;
    send_word(8'h10, 8'h01, 1'b1, 1'b0);
    send_word(8'h11, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    // X data offered while full must be ignored
    in_valid = 1'b1;
    in_a     = 'x;
    in_b     = 'x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fork
      begin
        send_word(8'h12, 8'h01, 1'b0, 1'b0);
        send_word(8'h13, 8'h01, 1'b0, 1'b1);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("bp_nogap", {31'd0, out_valid}, 32'd1);
        end
      end
    join
    drain();

    // Reset mid-packet; stale borrow must not leak into the next word
    send_word(8'h00, 8'h01, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    m_busy   = 1'b0;
    m_borrow = 1'b0;
    m_zero   = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    send_word(8'h05, 8'h02, 1'b0, 1'b1);
    drain();

    // Zero result packet 0x1234 - 0x1234
    send_word(8'h34, 8'h34, 1'b1, 1'b0);
    send_word(8'h12, 8'h12, 1'b0, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
